// File: rtl/serial_issue_queue.sv
// serial_issue_queue
//
// Purpose: a small in-order issue queue that hands its head entry to a
// serialising execution unit, one instruction at a time. The head is offered
// only when it is the oldest unretired instruction (head rob == commit_rob).
// After the unit accepts it, the queue waits until commit_rob moves past it
// and then pops it. A redirect squashes every entry that is not older than
// redirect_rob.
//
// Ports:
//   clk, rst      single clock, asynchronous active-high reset
//   enq_valid     per-lane dispatch request (ENQ_W lanes)
//   enq_data      per-lane payload, lane l at [l*DATA_W +: DATA_W]
//   enq_rob       per-lane ROB index, lane l at [l*ROB_W +: ROB_W]
//   enq_ready     high while at least ENQ_W entries are free
//   commit_rob    ROB index of the oldest unretired instruction
//   redirect      pipeline flush, with redirect_rob as the flush boundary
//   iss_valid     head entry offered to the unit
//   iss_ready     unit accepts the offered entry
//   iss_data      head payload
//   iss_rob       head ROB index
//   count         number of occupied entries
//   stall_cnt     (SERIAL_IQ_STALL_CNT_EN only) saturating count of cycles
//                 with a non-empty idle queue whose head is not yet oldest
//
// Optional feature macro: SERIAL_IQ_STALL_CNT_EN

module serial_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ROB_W  = 6,
  parameter int ENQ_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ENQ_W-1:0]          enq_valid,
  input  logic [ENQ_W*DATA_W-1:0]   enq_data,
  input  logic [ENQ_W*ROB_W-1:0]    enq_rob,
  output logic                      enq_ready,
  input  logic [ROB_W-1:0]          commit_rob,
  input  logic                      redirect,
  input  logic [ROB_W-1:0]          redirect_rob,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [DATA_W-1:0]         iss_data,
  output logic [ROB_W-1:0]          iss_rob,
  output logic [$clog2(DEPTH):0]    count
`ifdef SERIAL_IQ_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Pointers carry the wrap bit as their MSB, so plain modular subtraction
  // gives the occupancy and full/empty are distinguished by that bit.
  logic [CW-1:0]     head_ptr, tail_ptr;
  logic [CW-1:0]     head_next, tail_next;
  logic [CW-1:0]     occ_after_pop;
  logic [CW-1:0]     survivors;
  logic [CW-1:0]     enq_cnt;
  logic [1:0]        state, state_next;
  logic              enq_fire, pop, head_squashed, scanning;
  logic [PW-1:0]     slot;
  logic [PW-1:0]     lane_slot [ENQ_W];
  logic [ROB_W-1:0]  head_rob;

  logic [DATA_W-1:0] data_ram [DEPTH];
  logic [ROB_W-1:0]  rob_ram  [DEPTH];

  // ROB indices are {wrap, idx}; a differing wrap bit means b has lapped
  // the ROB once relative to a, which inverts the idx comparison.
  function automatic logic older(input logic [ROB_W-1:0] a,
                                 input logic [ROB_W-1:0] b);
    logic result;
    if (a[ROB_W-1] == b[ROB_W-1]) result = (a[ROB_W-2:0] < b[ROB_W-2:0]);
    else                          result = (a[ROB_W-2:0] > b[ROB_W-2:0]);
    return result;
  endfunction

  assign count         = tail_ptr - head_ptr;
  assign enq_ready     = (CW'(DEPTH) - count) >= CW'(ENQ_W);
  assign enq_fire      = enq_ready && !redirect && (|enq_valid);
  assign head_rob      = rob_ram[head_ptr[PW-1:0]];
  assign iss_rob       = head_rob;
  assign iss_data      = data_ram[head_ptr[PW-1:0]];
  assign iss_valid     = (state == ISSUE);
  assign pop           = (state == WAIT) && (commit_rob != head_rob);
  assign head_squashed = redirect && (count != '0) && !older(head_rob, redirect_rob);
  assign head_next     = head_ptr + CW'(pop);
  assign occ_after_pop = count - CW'(pop);

  // Valid lanes are packed into consecutive slots from the tail in lane
  // order, so each lane's slot is the tail plus the number of valid lanes
  // below it.
  always_comb begin
    enq_cnt = '0;
    for (int l = 0; l < ENQ_W; l++) begin
      lane_slot[l] = tail_ptr[PW-1:0] + enq_cnt[PW-1:0];
      if (enq_valid[l]) enq_cnt = enq_cnt + CW'(1);
    end
  end

  // Entries sit in age order, so the survivors of a redirect are the run of
  // entries from the (post-pop) head that are older than the boundary. The
  // new tail is placed directly after that run.
  always_comb begin
    survivors = '0;
    scanning  = 1'b1;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_next[PW-1:0] + PW'(i);
      if (scanning && (CW'(i) < occ_after_pop) && older(rob_ram[slot], redirect_rob))
        survivors = survivors + CW'(1);
      else
        scanning = 1'b0;
    end
  end

  always_comb begin
    if (redirect)      tail_next = head_next + survivors;
    else if (enq_fire) tail_next = tail_ptr + enq_cnt;
    else               tail_next = tail_ptr;
  end

  // Issue sequencing: wait for the head to become oldest, offer it, then
  // hold it until commit moves on. A redirect that squashes the head always
  // returns to IDLE; an unsquashed head keeps its progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((count != '0) && (head_rob == commit_rob) && !redirect)
                 state_next = ISSUE;
      ISSUE:   if (iss_ready) state_next = WAIT;
      WAIT:    if (pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (head_squashed) state_next = IDLE;
  end

  // Control state: pointers and sequencing state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      state    <= IDLE;
    end else begin
      head_ptr <= head_next;
      tail_ptr <= tail_next;
      state    <= state_next;
    end
  end

  // Payload storage is deliberately not reset; an entry is only ever read
  // after it has been written.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int l = 0; l < ENQ_W; l++) begin
        if (enq_valid[l]) begin
          data_ram[lane_slot[l]] <= enq_data[l*DATA_W +: DATA_W];
          rob_ram[lane_slot[l]]  <= enq_rob[l*ROB_W +: ROB_W];
        end
      end
    end
  end

`ifdef SERIAL_IQ_STALL_CNT_EN
  // Counts cycles lost waiting for the head to become the oldest
  // instruction; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((count != '0) && (state == IDLE) && (head_rob != commit_rob)
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_issue_queue.sv
// tb_serial_issue_queue
//
// Testbench for serial_issue_queue (DEPTH=4, DATA_W=64, ROB_W=6, ENQ_W=2).
// A reference model keeps the queue as a list of entries in age order plus
// two flags (head offered / head handed off) and is stepped once per cycle
// from the same inputs the design sees. Directed scenarios are followed by
// a randomized phase whose ROB indices cross the 6-bit wrap repeatedly.
// Also checks stall_cnt when SERIAL_IQ_STALL_CNT_EN is defined.

module tb_serial_issue_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ROB_W  = 6;
  localparam int ENQ_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [ENQ_W-1:0]        enq_valid;
  logic [ENQ_W*DATA_W-1:0] enq_data;
  logic [ENQ_W*ROB_W-1:0]  enq_rob;
  logic                    enq_ready;
  logic [ROB_W-1:0]        commit_rob;
  logic                    redirect;
  logic [ROB_W-1:0]        redirect_rob;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [DATA_W-1:0]       iss_data;
  logic [ROB_W-1:0]        iss_rob;
  logic [$clog2(DEPTH):0]  count;
`ifdef SERIAL_IQ_STALL_CNT_EN
  logic [31:0]             stall_cnt;
`endif

  serial_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .ENQ_W(ENQ_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enq_valid(enq_valid),
    .enq_data(enq_data),
    .enq_rob(enq_rob),
    .enq_ready(enq_ready),
    .commit_rob(commit_rob),
    .redirect(redirect),
    .redirect_rob(redirect_rob),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .iss_data(iss_data),
    .iss_rob(iss_rob),
    .count(count)
`ifdef SERIAL_IQ_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t           mq[$];
  bit               m_offered;
  bit               m_accepted;
  logic [31:0]      m_stall;
  logic [ROB_W-1:0] next_rob;
  int               checks;
  int               errors;

  // a is older than b when b lies less than half the ROB ahead of a.
  function automatic bit isOlder(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    logic [ROB_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[ROB_W-1];
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("count", 64'(count), 64'(mq.size()));
    checkVal("enq_ready", 64'(enq_ready), 64'((DEPTH - mq.size()) >= ENQ_W));
    checkVal("iss_valid", 64'(iss_valid), 64'(m_offered));
    if (m_offered) begin
      checkVal("iss_rob", 64'(iss_rob), 64'(mq[0].rob));
      checkVal("iss_data", 64'(iss_data), 64'(mq[0].data));
    end
`ifdef SERIAL_IQ_STALL_CNT_EN
    checkVal("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic doReset();
    enq_valid = '0;
    redirect  = 1'b0;
    iss_ready = 1'b0;
    rst       = 1'b1;
    #2;
    mq.delete();
    m_offered  = 1'b0;
    m_accepted = 1'b0;
    m_stall    = '0;
    checkVal("rst_count", 64'(count), 64'd0);
    checkVal("rst_iss_valid", 64'(iss_valid), 64'd0);
    checkVal("rst_enq_ready", 64'(enq_ready), 64'd1);
`ifdef SERIAL_IQ_STALL_CNT_EN
    checkVal("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the model by one cycle, then
  // compares on the following falling edge. Valid lanes take consecutive
  // ROB indices starting at next_rob.
  task automatic applyStimulus(input logic [ENQ_W-1:0] ev, input logic [ROB_W-1:0] cr,
                               input logic rd, input logic [ROB_W-1:0] rr, input logic ir);
    entry_t           lanes[ENQ_W];
    logic [ROB_W-1:0] r;
    int               sz;
    bit               fire, do_pop, squash;
    r = next_rob;
    for (int l = 0; l < ENQ_W; l++) begin
      lanes[l].data = {$urandom, $urandom};
      if (ev[l]) begin
        lanes[l].rob = r;
        r = r + 1'b1;
      end else begin
        lanes[l].rob = ROB_W'($urandom);
      end
      enq_data[l*DATA_W +: DATA_W] = lanes[l].data;
      enq_rob[l*ROB_W +: ROB_W]    = lanes[l].rob;
    end
    enq_valid    = ev;
    commit_rob   = cr;
    redirect     = rd;
    redirect_rob = rr;
    iss_ready    = ir;

    sz     = mq.size();
    fire   = ((DEPTH - sz) >= ENQ_W) && !rd;
    do_pop = m_accepted && (mq[0].rob != cr);
    squash = rd && (sz > 0) && !isOlder(mq[0].rob, rr);
    if ((sz > 0) && !m_offered && !m_accepted && (mq[0].rob != cr) && (m_stall != '1))
      m_stall = m_stall + 1;
    if (m_accepted) begin
      if (do_pop) m_accepted = 1'b0;
    end else if (m_offered) begin
      if (ir) begin
        m_offered  = 1'b0;
        m_accepted = 1'b1;
      end
    end else if ((sz > 0) && (mq[0].rob == cr) && !rd) begin
      m_offered = 1'b1;
    end
    if (squash) begin
      m_offered  = 1'b0;
      m_accepted = 1'b0;
    end
    if (do_pop) void'(mq.pop_front());
    if (rd) begin
      while ((mq.size() > 0) && !isOlder(mq[$].rob, rr)) void'(mq.pop_back());
      next_rob = rr;
    end else if (fire) begin
      for (int l = 0; l < ENQ_W; l++) if (ev[l]) mq.push_back(lanes[l]);
      next_rob = r;
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ENQ_W-1:0] ev;
    logic [ROB_W-1:0] cr, rr;
    logic             rd, ir;
    int               k;
    checks       = 0;
    errors       = 0;
    enq_data     = '0;
    enq_rob      = '0;
    commit_rob   = '0;
    redirect_rob = '0;
    next_rob     = '0;
    doReset();

    // Two-lane dispatch, issue two cycles after enqueue, pop on commit move.
    next_rob = 6'd3;
    applyStimulus(2'b11, 6'd3, 1'b0, 6'd0, 1'b0);
    checkVal("basic_count", 64'(count), 64'd2);
    applyStimulus(2'b00, 6'd3, 1'b0, 6'd0, 1'b0);
    checkVal("basic_first_rob", 64'(iss_rob), 64'd3);
    applyStimulus(2'b00, 6'd3, 1'b0, 6'd0, 1'b1);
    applyStimulus(2'b00, 6'd4, 1'b0, 6'd0, 1'b0);
    checkVal("basic_pop_count", 64'(count), 64'd1);
    applyStimulus(2'b00, 6'd4, 1'b0, 6'd0, 1'b0);
    checkVal("basic_second_rob", 64'(iss_rob), 64'd4);

    // Fill to capacity; further dispatch is refused.
    doReset();
    next_rob = 6'd10;
    applyStimulus(2'b11, 6'd0, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b11, 6'd0, 1'b0, 6'd0, 1'b0);
    checkVal("full_enq_ready", 64'(enq_ready), 64'd0);
    applyStimulus(2'b11, 6'd0, 1'b0, 6'd0, 1'b0);
    checkVal("full_count", 64'(count), 64'd4);

    // Partial squash keeps the older head.
    doReset();
    next_rob = 6'd5;
    applyStimulus(2'b11, 6'd0, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b01, 6'd0, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b00, 6'd0, 1'b1, 6'd6, 1'b0);
    checkVal("squash_count", 64'(count), 64'd1);
    checkVal("squash_head_rob", 64'(iss_rob), 64'd5);

    // Squash of a waiting head with a coincident dispatch.
    doReset();
    next_rob = 6'd2;
    applyStimulus(2'b01, 6'd2, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b00, 6'd2, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b00, 6'd2, 1'b0, 6'd0, 1'b1);
    applyStimulus(2'b11, 6'd2, 1'b1, 6'd2, 1'b0);
    checkVal("headsquash_count", 64'(count), 64'd0);
    checkVal("headsquash_iss_valid", 64'(iss_valid), 64'd0);
    applyStimulus(2'b00, 6'd2, 1'b0, 6'd0, 1'b0);

    // Reset while the head is being offered.
    doReset();
    next_rob = 6'd9;
    applyStimulus(2'b01, 6'd9, 1'b0, 6'd0, 1'b0);
    applyStimulus(2'b00, 6'd9, 1'b0, 6'd0, 1'b0);
    checkVal("midrst_offered", 64'(iss_valid), 64'd1);
    doReset();
    applyStimulus(2'b00, 6'd9, 1'b0, 6'd0, 1'b0);
    checkVal("midrst_after_valid", 64'(iss_valid), 64'd0);

`ifdef SERIAL_IQ_STALL_CNT_EN
    // Head waits ten cycles for commit to reach it.
    doReset();
    next_rob = 6'd8;
    applyStimulus(2'b01, 6'd7, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(2'b00, 6'd7, 1'b0, 6'd0, 1'b0);
    checkVal("stall_ten", 64'(stall_cnt), 64'd10);
    doReset();
`endif

    // Random traffic starting just below the ROB wrap point.
    doReset();
    next_rob = 6'd28;
    for (int c = 0; c < 800; c++) begin
      ev = ENQ_W'($urandom);
      if (mq.size() > 0)
        cr = ($urandom_range(2, 0) != 0) ? mq[0].rob : mq[0].rob + 1'b1;
      else
        cr = ROB_W'($urandom);
      rd = ($urandom_range(15, 0) == 0);
      k  = $urandom_range(mq.size(), 0);
      rr = (k < mq.size()) ? mq[k].rob : next_rob;
      ir = 1'($urandom_range(1, 0));
      applyStimulus(ev, cr, rd, rr, ir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
